// File: rtl/key_rotary_frontend_if.sv
// Pin-side bundle for the key/rotary front-end: raw board inputs in, debounced events out.
// The master drives the raw pins and the slave is the front-end itself.
interface key_rotary_frontend_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] i_key_n;
  logic [3:0]        i_rotary;
  logic [N_KEYS-1:0] o_key_level;
  logic [N_KEYS-1:0] o_key_press;
  logic [N_KEYS-1:0] o_key_release;
  logic [N_KEYS-1:0] o_key_long;
  logic [3:0]        o_rotary;
  logic              o_rot_chg;
  logic              o_rot_dir;

  modport master (
    output i_key_n, i_rotary,
    input  o_key_level, o_key_press, o_key_release, o_key_long,
    input  o_rotary, o_rot_chg, o_rot_dir
  );

  modport slave (
    input  i_key_n, i_rotary,
    output o_key_level, o_key_press, o_key_release, o_key_long,
    output o_rotary, o_rot_chg, o_rot_dir
  );
endinterface

// File: rtl/key_rotary_frontend.sv
// Push-button and rotary-switch front-end: 2-FF synchronisers, per-key debounce FSM with
// press/release/long-press strobes, and a debounced rotary code with change strobe and direction.
module key_rotary_frontend #(
  parameter int N_KEYS      = 2,
  parameter int DB_CYCLES   = 100000,
  parameter int LONG_CYCLES = 10000000
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  key_rotary_frontend_if.slave  bus
);

  localparam int KCW = $clog2(LONG_CYCLES + 1);
  localparam int RCW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  localparam logic [KCW-1:0] KEY_DB_LAST = KCW'(DB_CYCLES - 1);
  localparam logic [KCW-1:0] LONG_MAX    = KCW'(LONG_CYCLES);
  localparam logic [KCW-1:0] LONG_LAST   = KCW'(LONG_CYCLES - 1);
  localparam logic [RCW-1:0] ROT_DB_LAST = RCW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } key_state_t;

  // Synchronisers: keys reset to the released level (1), rotary to 0.
  logic [N_KEYS-1:0] key_meta, key_sync;
  logic [3:0]        rot_meta, rot_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      key_meta <= '1;
      key_sync <= '1;
      rot_meta <= '0;
      rot_sync <= '0;
    end else begin
      key_meta <= bus.i_key_n;
      key_sync <= key_meta;
      rot_meta <= bus.i_rotary;
      rot_sync <= rot_meta;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_state_t     state;
    logic [KCW-1:0] cnt;
    logic           level_q, press_q, release_q, long_q;
    logic           pressed;

    assign pressed = ~key_sync[k];

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        unique case (state)
          IDLE: begin
            if (pressed) begin
              state <= PRESS_DB;
              cnt   <= '0;
            end
          end
          PRESS_DB: begin
            if (!pressed) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == KEY_DB_LAST) begin
              state   <= HELD;
              cnt     <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            // Saturating hold counter: the long strobe fires once, when it first hits the top.
            if (!pressed) begin
              state <= RELEASE_DB;
              cnt   <= '0;
            end else if (cnt != LONG_MAX) begin
              cnt <= cnt + 1'b1;
              if (cnt == LONG_LAST) long_q <= 1'b1;
            end
          end
          RELEASE_DB: begin
            // A re-press during release debounce resumes HELD silently with a fresh hold count.
            if (pressed) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == KEY_DB_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign bus.o_key_level[k]   = level_q;
    assign bus.o_key_press[k]   = press_q;
    assign bus.o_key_release[k] = release_q;
    assign bus.o_key_long[k]    = long_q;
  end

  logic [3:0]     rot_cand;
  logic [RCW-1:0] rot_cnt;
  logic [3:0]     rot_q;
  logic           rot_chg_q, rot_dir_q;
  logic [3:0]     rot_diff;

  // Modulo-16 step from the current output to the candidate; below 8 counts as "up".
  assign rot_diff = rot_cand - rot_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rot_cand  <= '0;
      rot_cnt   <= '0;
      rot_q     <= '0;
      rot_chg_q <= 1'b0;
      rot_dir_q <= 1'b0;
    end else begin
      rot_chg_q <= 1'b0;
      if (rot_sync != rot_cand) begin
        rot_cand <= rot_sync;
        rot_cnt  <= '0;
      end else if (rot_cand != rot_q) begin
        if (rot_cnt == ROT_DB_LAST) begin
          rot_q     <= rot_cand;
          rot_chg_q <= 1'b1;
          rot_dir_q <= ~rot_diff[3];
          rot_cnt   <= '0;
        end else begin
          rot_cnt <= rot_cnt + 1'b1;
        end
      end else begin
        rot_cnt <= '0;
      end
    end
  end

  assign bus.o_rotary  = rot_q;
  assign bus.o_rot_chg = rot_chg_q;
  assign bus.o_rot_dir = rot_dir_q;

endmodule

// File: tb/tb_key_rotary_frontend.sv
// Directed bench for key_rotary_frontend with DB_CYCLES=16, LONG_CYCLES=64.
// Event strobes are counted and time-stamped on the falling edge and compared to hand-derived values.
module tb_key_rotary_frontend;

  localparam int DB   = 16;
  localparam int LONG = 64;
  localparam int LAT  = DB + 3;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_rotary_frontend_if #(.N_KEYS(2)) bus ();

  key_rotary_frontend #(
    .N_KEYS      (2),
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int press_tot [2] = '{0, 0};
  int rel_tot   [2] = '{0, 0};
  int long_tot  [2] = '{0, 0};
  int press_cyc [2] = '{0, 0};
  int rel_cyc   [2] = '{0, 0};
  int long_cyc  [2] = '{0, 0};
  int chg_tot = 0;
  int chg_cyc = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bus.o_key_press[k])   begin press_tot[k] <= press_tot[k] + 1; press_cyc[k] <= cyc; end
      if (bus.o_key_release[k]) begin rel_tot[k]   <= rel_tot[k] + 1;   rel_cyc[k]   <= cyc; end
      if (bus.o_key_long[k])    begin long_tot[k]  <= long_tot[k] + 1;  long_cyc[k]  <= cyc; end
    end
    if (bus.o_rot_chg) begin chg_tot <= chg_tot + 1; chg_cyc <= cyc; end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int key;
    int hold;
    int exp_press;
    int exp_release;
    int exp_long;
  } key_vec_t;

  typedef struct {
    logic [3:0] val;
    int         hold;
    int         exp_chg;
    logic       exp_dir;
    logic [3:0] exp_rot;
  } rot_vec_t;

  key_vec_t key_vecs [6];
  rot_vec_t rot_vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, p0, p1, r0, r1, l0, l1, c0, o;

    // Hold time vs expected strobes: 16 cycles is one short of debounce, 81 is the first long press.
    key_vecs = '{
      '{0,  10, 0, 0, 0},
      '{1,  16, 0, 0, 0},
      '{0,  17, 1, 1, 0},
      '{1,  80, 1, 1, 0},
      '{0,  81, 1, 1, 1},
      '{1, 200, 1, 1, 1}
    };
    // Starts from o_rotary=5 after the reset test.
    rot_vecs = '{
      '{4'd14, 30, 1, 1'b0, 4'd14},
      '{4'd15, 30, 1, 1'b1, 4'd15},
      '{4'd0,  30, 1, 1'b1, 4'd0},
      '{4'd15, 30, 1, 1'b0, 4'd15},
      '{4'd3,  10, 0, 1'b0, 4'd15},
      '{4'd15, 30, 0, 1'b0, 4'd15},
      '{4'd7,  30, 1, 1'b0, 4'd7},
      '{4'd8,  30, 1, 1'b1, 4'd8},
      '{4'd0,  30, 1, 1'b0, 4'd0}
    };

    // 1: reset with keys pressed and rotary at 5
    rstn         = 1'b0;
    bus.i_key_n  = 2'b00;
    bus.i_rotary = 4'd5;
    cycles(5);
    check("rst_level",   32'(bus.o_key_level),   0);
    check("rst_press",   32'(bus.o_key_press),   0);
    check("rst_release", 32'(bus.o_key_release), 0);
    check("rst_long",    32'(bus.o_key_long),    0);
    check("rst_rotary",  32'(bus.o_rotary),      0);
    check("rst_chg",     32'(bus.o_rot_chg),     0);
    check("rst_dir",     32'(bus.o_rot_dir),     0);
    bus.i_key_n = 2'b11;
    rstn = 1'b1;
    t  = cyc;
    c0 = chg_tot;
    cycles(30);
    check("rst_rot_chg_count", chg_tot - c0, 1);
    check("rst_rot_chg_lat",   chg_cyc - t, LAT);
    check("rst_rot_value",     32'(bus.o_rotary), 5);
    check("rst_rot_dir",       32'(bus.o_rot_dir), 1);
    check("rst_no_key_press",  press_tot[0] + press_tot[1], 0);

    // 2: clean 40-cycle press of key0
    p0 = press_tot[0]; r0 = rel_tot[0]; l0 = long_tot[0];
    bus.i_key_n[0] = 1'b0;
    t = cyc;
    cycles(40);
    check("clean_press_count", press_tot[0] - p0, 1);
    check("clean_press_lat",   press_cyc[0] - t, LAT);
    check("clean_level_high",  32'(bus.o_key_level[0]), 1);
    bus.i_key_n[0] = 1'b1;
    t = cyc;
    cycles(40);
    check("clean_release_count", rel_tot[0] - r0, 1);
    check("clean_release_lat",   rel_cyc[0] - t, LAT);
    check("clean_no_long",       long_tot[0] - l0, 0);
    check("clean_level_low",     32'(bus.o_key_level[0]), 0);

    // 3: key1 bounces every 5 cycles for 60 cycles, then settles pressed
    p0 = press_tot[0]; p1 = press_tot[1]; r1 = rel_tot[1];
    for (int i = 0; i < 12; i++) begin
      bus.i_key_n[1] = i[0];
      cycles(5);
    end
    check("bounce_no_press_yet", press_tot[1] - p1, 0);
    bus.i_key_n[1] = 1'b0;
    t = cyc;
    cycles(40);
    check("bounce_press_count",  press_tot[1] - p1, 1);
    check("bounce_press_lat",    press_cyc[1] - t, LAT);
    check("bounce_no_release",   rel_tot[1] - r1, 0);
    check("bounce_key0_quiet",   press_tot[0] - p0, 0);
    bus.i_key_n[1] = 1'b1;
    cycles(40);

    // 4: 200-cycle hold of key0 with long-press timing
    p0 = press_tot[0]; r0 = rel_tot[0]; l0 = long_tot[0];
    bus.i_key_n[0] = 1'b0;
    cycles(200);
    check("long_press_count", press_tot[0] - p0, 1);
    check("long_count_held",  long_tot[0] - l0, 1);
    check("long_after_press", long_cyc[0] - press_cyc[0], LONG);
    bus.i_key_n[0] = 1'b1;
    cycles(40);
    check("long_release_count", rel_tot[0] - r0, 1);
    check("long_single_pulse",  long_tot[0] - l0, 1);

    // Table: single-key holds around the debounce and long-press thresholds
    foreach (key_vecs[i]) begin
      o  = 1 - key_vecs[i].key;
      p0 = press_tot[key_vecs[i].key];
      r0 = rel_tot[key_vecs[i].key];
      l0 = long_tot[key_vecs[i].key];
      p1 = press_tot[o] + rel_tot[o] + long_tot[o];
      bus.i_key_n[key_vecs[i].key] = 1'b0;
      cycles(key_vecs[i].hold);
      bus.i_key_n[key_vecs[i].key] = 1'b1;
      cycles(60);
      check($sformatf("keyvec%0d_press", i),   press_tot[key_vecs[i].key] - p0, key_vecs[i].exp_press);
      check($sformatf("keyvec%0d_release", i), rel_tot[key_vecs[i].key] - r0,   key_vecs[i].exp_release);
      check($sformatf("keyvec%0d_long", i),    long_tot[key_vecs[i].key] - l0,  key_vecs[i].exp_long);
      check($sformatf("keyvec%0d_other", i),   press_tot[o] + rel_tot[o] + long_tot[o] - p1, 0);
    end

    // Simultaneous press and release of both keys
    bus.i_key_n = 2'b00;
    t = cyc;
    cycles(30);
    check("both_press_lat0", press_cyc[0] - t, LAT);
    check("both_press_lat1", press_cyc[1] - t, LAT);
    bus.i_key_n = 2'b11;
    t = cyc;
    cycles(40);
    check("both_release_lat0", rel_cyc[0] - t, LAT);
    check("both_release_lat1", rel_cyc[1] - t, LAT);

    // Table: rotary walk including wrap, a short blip and a half-turn step
    foreach (rot_vecs[i]) begin
      c0 = chg_tot;
      bus.i_rotary = rot_vecs[i].val;
      cycles(rot_vecs[i].hold);
      check($sformatf("rotvec%0d_chg", i),   chg_tot - c0,           rot_vecs[i].exp_chg);
      check($sformatf("rotvec%0d_value", i), 32'(bus.o_rotary),      32'(rot_vecs[i].exp_rot));
      check($sformatf("rotvec%0d_dir", i),   32'(bus.o_rot_dir),     32'(rot_vecs[i].exp_dir));
    end

    // 6: one-cycle reset while key0 is mid press-debounce (counter at 10)
    p0 = press_tot[0];
    bus.i_key_n[0] = 1'b0;
    t = cyc;
    cycles(13);
    rstn = 1'b0;
    cycles(1);
    check("midrst_level", 32'(bus.o_key_level[0]), 0);
    rstn = 1'b1;
    t = cyc;
    cycles(10);
    check("midrst_no_press", press_tot[0] - p0, 0);
    cycles(20);
    check("midrst_press_count", press_tot[0] - p0, 1);
    check("midrst_press_lat",   press_cyc[0] - t, LAT);
    check("midrst_level_high",  32'(bus.o_key_level[0]), 1);
    bus.i_key_n[0] = 1'b1;
    cycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
